// File: rtl/core_common.sv
// Shared memory-bus widths, arbiter state encoding and command struct.
// Imported by every file in the memory-arbiter slice.
package core_common;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_DATA  = 1'b0;
  localparam logic OWN_FETCH = 1'b1;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Fetch, LSU and shared memory bus signals of the core memory arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface core_mem_arbiter_if;
  import core_common::*;

  logic                  imem_req;
  logic [MEM_ADDR_W-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_err;
  logic [MEM_DATA_W-1:0] imem_rdata;

  logic                  dmem_req;
  logic [MEM_ADDR_W-1:0] dmem_addr;
  logic                  dmem_wen;
  logic [MEM_STRB_W-1:0] dmem_strb;
  logic [MEM_DATA_W-1:0] dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_err;
  logic [MEM_DATA_W-1:0] dmem_rdata;

  logic                  mem_req;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_wen;
  logic [MEM_STRB_W-1:0] mem_strb;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rsp;
  logic                  mem_err;
  logic [MEM_DATA_W-1:0] mem_rdata;

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_err, imem_rdata,
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_err, dmem_rdata,
    output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    input  mem_gnt, mem_rsp, mem_err, mem_rdata
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_err, imem_rdata,
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_err, dmem_rdata,
    input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    output mem_gnt, mem_rsp, mem_err, mem_rdata
  );

endinterface

// File: rtl/core_mem_arbiter_prio.sv
// Data-over-fetch priority pick with a saturating fetch-starvation counter.
module core_mem_arbiter_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic imem_req_i,
  input  logic dmem_req_i,
  input  logic data_acc_i,
  input  logic fetch_acc_i,
  output logic pick_fetch_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only tracks data wins taken while fetch is actually waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (!imem_req_i || fetch_acc_i)
      cnt_d = '0;
    else if (data_acc_i && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign pick_fetch_o = imem_req_i && (!dmem_req_i || (cnt_q == CNT_MAX));

endmodule

// File: rtl/core_mem_arbiter.sv
// Two-requester (fetch, LSU) arbiter onto one memory port with split
// address/response phases; one transaction outstanding at a time.
module core_mem_arbiter
  import core_common::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  core_mem_arbiter_if.slave  bus
);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       owner;
  logic       any_req;
  logic       pick_fetch;
  logic       addr_acc;
  logic       rsp_fire;
  mem_cmd_t   cmd;

  assign any_req = bus.imem_req | bus.dmem_req;

  // In IDLE the pick drives the bus the same cycle; afterwards the owner is frozen.
  assign owner = (state_q == ST_IDLE) ? (pick_fetch ? OWN_FETCH : OWN_DATA) : owner_q;

  always_comb begin
    if (owner == OWN_FETCH) begin
      cmd.addr  = bus.imem_addr;
      cmd.wen   = 1'b0;
      cmd.strb  = '0;
      cmd.wdata = '0;
    end else begin
      cmd.addr  = bus.dmem_addr;
      cmd.wen   = bus.dmem_wen;
      cmd.strb  = bus.dmem_strb;
      cmd.wdata = bus.dmem_wdata;
    end
  end

  assign bus.mem_req   = g_resetn && (((state_q == ST_IDLE) && any_req) || (state_q == ST_ADDR));
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wen   = cmd.wen;
  assign bus.mem_strb  = cmd.strb;
  assign bus.mem_wdata = cmd.wdata;

  assign addr_acc = bus.mem_req && bus.mem_gnt;
  assign rsp_fire = g_resetn && (state_q == ST_RESP) && bus.mem_rsp;

  assign bus.imem_gnt   = rsp_fire && (owner_q == OWN_FETCH);
  assign bus.dmem_gnt   = rsp_fire && (owner_q == OWN_DATA);
  assign bus.imem_rdata = bus.imem_gnt ? bus.mem_rdata : '0;
  assign bus.dmem_rdata = bus.dmem_gnt ? bus.mem_rdata : '0;
  assign bus.imem_err   = bus.imem_gnt & bus.mem_err;
  assign bus.dmem_err   = bus.dmem_gnt & bus.mem_err;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: if (any_req) begin
        owner_d = owner;
        state_d = bus.mem_gnt ? ST_RESP : ST_ADDR;
      end
      ST_ADDR: if (bus.mem_gnt) state_d = ST_RESP;
      ST_RESP: if (bus.mem_rsp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  core_mem_arbiter_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .imem_req_i   (bus.imem_req),
    .dmem_req_i   (bus.dmem_req),
    .data_acc_i   (addr_acc && (owner == OWN_DATA)),
    .fetch_acc_i  (addr_acc && (owner == OWN_FETCH)),
    .pick_fetch_o (pick_fetch)
  );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench: expected address phases and responses are queued by the
// stimulus; a monitor pops them as the DUT presents mem_gnt / imem_gnt / dmem_gnt.
module tb_core_mem_arbiter;
  import core_common::*;

  typedef struct packed {
    logic        fetch;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  core_mem_arbiter_if bus();

  core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  mem_cmd_t exp_a[$];
  exp_rsp_t exp_r[$];
  int   tests = 0;
  int   fails = 0;
  int   gnt_dly = 0;
  int   rsp_dly = 2;
  logic err_cfg = 1'b0;

  function automatic mem_cmd_t cmd(input logic [31:0] a, input logic w,
                                   input logic [3:0] s, input logic [31:0] d);
    mem_cmd_t c;
    c.addr = a; c.wen = w; c.strb = s; c.wdata = d;
    return c;
  endfunction

  function automatic exp_rsp_t rsp(input logic f, input logic [31:0] d, input logic e);
    exp_rsp_t r;
    r.fetch = f; r.rdata = d; r.err = e;
    return r;
  endfunction

  // Memory content model: one marker word, everything else address-derived.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input bit fetch, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge g_clk); #1;
      got = fetch ? bus.imem_gnt : bus.dmem_gnt;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s: got no gnt expected gnt within 100 cycles", name);
    end
  endtask

  // Memory responder: grant after gnt_dly cycles, respond rsp_dly cycles later.
  initial begin
    int st, cnt;
    logic [31:0] la;
    st = 0; cnt = 0; la = '0;
    bus.mem_gnt = 1'b0; bus.mem_rsp = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge g_clk);
      bus.mem_gnt = 1'b0; bus.mem_rsp = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;
      case (st)
        0: if (bus.mem_req) begin
          if (gnt_dly == 0) begin
            bus.mem_gnt = 1'b1; la = bus.mem_addr; cnt = rsp_dly; st = 2;
          end else begin
            cnt = gnt_dly; st = 1;
          end
        end
        1: begin
          cnt--;
          if (cnt == 0) begin
            bus.mem_gnt = 1'b1; la = bus.mem_addr; cnt = rsp_dly; st = 2;
          end
        end
        default: begin
          cnt--;
          if (cnt == 0) begin
            bus.mem_rsp = 1'b1; bus.mem_rdata = mem_val(la); bus.mem_err = err_cfg; st = 0;
          end
        end
      endcase
    end
  end

  // Monitor
  initial begin
    mem_cmd_t ea;
    exp_rsp_t er;
    forever begin
      @(negedge g_clk); #1;
      if (bus.mem_req && bus.mem_gnt) begin
        if (exp_a.size() == 0) chk("unexpected_addr_phase", {1'b1, bus.mem_addr}, 0);
        else begin
          ea = exp_a.pop_front();
          chk("mem_addr", bus.mem_addr, ea.addr);
          chk("mem_wen", bus.mem_wen, ea.wen);
          chk("mem_strb", bus.mem_strb, ea.strb);
          chk("mem_wdata", bus.mem_wdata, ea.wdata);
        end
      end
      if (bus.imem_gnt || bus.dmem_gnt) begin
        chk("single_gnt", bus.imem_gnt & bus.dmem_gnt, 0);
        if (exp_r.size() == 0) chk("unexpected_gnt", {bus.imem_gnt, bus.dmem_gnt}, 0);
        else begin
          er = exp_r.pop_front();
          chk("rsp_owner_fetch", bus.imem_gnt, er.fetch);
          chk("rsp_rdata", er.fetch ? bus.imem_rdata : bus.dmem_rdata, er.rdata);
          chk("rsp_err", er.fetch ? bus.imem_err : bus.dmem_err, er.err);
        end
      end
      if (bus.mem_rsp && !bus.imem_gnt) chk("imem_quiet", {bus.imem_err, bus.imem_rdata}, 0);
      if (bus.mem_rsp && !bus.dmem_gnt) chk("dmem_quiet", {bus.dmem_err, bus.dmem_rdata}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.imem_req = 1'b0; bus.imem_addr = '0;
    bus.dmem_req = 1'b0; bus.dmem_addr = '0; bus.dmem_wen = 1'b0;
    bus.dmem_strb = '0; bus.dmem_wdata = '0;

    // Reset state, with both requesters asserted
    repeat (2) @(posedge g_clk); #1;
    bus.imem_req = 1'b1; bus.dmem_req = 1'b1; bus.imem_addr = 32'h44;
    @(negedge g_clk); #1;
    chk("rst_outputs", {bus.mem_req, bus.imem_gnt, bus.dmem_gnt}, 0);
    bus.imem_req = 1'b0; bus.dmem_req = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;

    // Data-only read, zero-latency address phase
    exp_a.push_back(cmd(32'h1000, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b0, 32'hDEADBEEF, 1'b0));
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h1000; bus.dmem_req = 1'b1;
    @(negedge g_clk); #1;
    chk("same_cycle_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h1000});
    wait_gnt(1'b0, "read_gnt");
    @(posedge g_clk); #1;
    bus.dmem_req = 1'b0;
    @(negedge g_clk); #1;
    chk("gnt_one_cycle", bus.dmem_gnt, 0);

    // Simultaneous requests: data first, fetch the cycle after data response
    exp_a.push_back(cmd(32'h2000, 1'b0, 4'h0, 32'h0));
    exp_a.push_back(cmd(32'h3000, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b0, 32'h5A5A2000, 1'b0));
    exp_r.push_back(rsp(1'b1, 32'h5A5A3000, 1'b0));
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h2000; bus.dmem_req = 1'b1;
    bus.imem_addr = 32'h3000; bus.imem_req = 1'b1;
    wait_gnt(1'b0, "both_data_gnt");
    @(posedge g_clk); #1;
    bus.dmem_req = 1'b0;
    @(negedge g_clk); #1;
    chk("fetch_next_cycle", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h3000});
    wait_gnt(1'b1, "both_fetch_gnt");
    @(posedge g_clk); #1;
    bus.imem_req = 1'b0;

    // Starvation: 4 data wins, fetch 5th, then remaining data
    for (int k = 0; k < 4; k++) begin
      exp_a.push_back(cmd(32'(32'h100 + 4 * k), 1'b0, 4'h0, 32'h0));
      exp_r.push_back(rsp(1'b0, mem_val(32'(32'h100 + 4 * k)), 1'b0));
    end
    exp_a.push_back(cmd(32'h400, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b1, 32'h5A5A0400, 1'b0));
    exp_a.push_back(cmd(32'h110, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b0, 32'h5A5A0110, 1'b0));
    @(posedge g_clk); #1;
    bus.imem_addr = 32'h400; bus.imem_req = 1'b1;
    bus.dmem_addr = 32'h100; bus.dmem_req = 1'b1;
    fork
      begin
        wait_gnt(1'b1, "starve_fetch_gnt");
        @(posedge g_clk); #1;
        bus.imem_req = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          bus.dmem_addr = 32'(32'h100 + 4 * k);
          wait_gnt(1'b0, "starve_data_gnt");
          @(posedge g_clk); #1;
        end
        bus.dmem_req = 1'b0;
      end
    join

    // Address phase stall: owner stays fetch while data arrives mid-ADDR
    gnt_dly = 3;
    exp_a.push_back(cmd(32'h500, 1'b0, 4'h0, 32'h0));
    exp_a.push_back(cmd(32'h600, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b1, 32'h5A5A0500, 1'b0));
    exp_r.push_back(rsp(1'b0, 32'h5A5A0600, 1'b0));
    @(posedge g_clk); #1;
    bus.imem_addr = 32'h500; bus.imem_req = 1'b1;
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h600; bus.dmem_req = 1'b1;
    @(negedge g_clk); #1;
    chk("addr_hold_fetch", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h500});
    wait_gnt(1'b1, "stall_fetch_gnt");
    @(posedge g_clk); #1;
    bus.imem_req = 1'b0;
    wait_gnt(1'b0, "stall_data_gnt");
    @(posedge g_clk); #1;
    bus.dmem_req = 1'b0;
    gnt_dly = 0;

    // Store with error response, then a fetch must not leak store fields
    err_cfg = 1'b1;
    exp_a.push_back(cmd(32'h20, 1'b1, 4'hF, 32'h12345678));
    exp_r.push_back(rsp(1'b0, 32'h5A5A0020, 1'b1));
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h20; bus.dmem_wen = 1'b1; bus.dmem_strb = 4'hF;
    bus.dmem_wdata = 32'h12345678; bus.dmem_req = 1'b1;
    wait_gnt(1'b0, "store_gnt");
    @(posedge g_clk); #1;
    bus.dmem_req = 1'b0;
    err_cfg = 1'b0;
    exp_a.push_back(cmd(32'h40, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b1, 32'h5A5A0040, 1'b0));
    bus.imem_addr = 32'h40; bus.imem_req = 1'b1;
    wait_gnt(1'b1, "fetch_after_store_gnt");
    @(posedge g_clk); #1;
    bus.imem_req = 1'b0;
    bus.dmem_wen = 1'b0; bus.dmem_strb = '0; bus.dmem_wdata = '0;

    // Reset in RESP; late mem_rsp must produce nothing
    rsp_dly = 6;
    exp_a.push_back(cmd(32'h700, 1'b0, 4'h0, 32'h0));
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h700; bus.dmem_req = 1'b1;
    @(posedge g_clk); #1;
    g_resetn = 1'b0; bus.dmem_req = 1'b0;
    @(negedge g_clk); #1;
    chk("mid_rst_outputs", {bus.mem_req, bus.imem_gnt, bus.dmem_gnt}, 0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge g_clk); #1;
      chk("post_rst_quiet", {bus.mem_req, bus.imem_gnt, bus.dmem_gnt}, 0);
    end

    // Fresh transaction after the abandoned one
    rsp_dly = 2;
    exp_a.push_back(cmd(32'h800, 1'b0, 4'h0, 32'h0));
    exp_r.push_back(rsp(1'b0, 32'h5A5A0800, 1'b0));
    @(posedge g_clk); #1;
    bus.dmem_addr = 32'h800; bus.dmem_req = 1'b1;
    wait_gnt(1'b0, "post_rst_gnt");
    @(posedge g_clk); #1;
    bus.dmem_req = 1'b0;

    repeat (4) @(negedge g_clk);
    #2;
    chk("scoreboard_drained", exp_a.size() + exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIMIT, default 4: consecutive data-side wins allowed while fetch waits.
REQ-002 SHALL have port g_clk  in  1  global clock.
REQ-003 SHALL have port g_resetn  in  1  reset: synchronous, active-low.
REQ-004 SHALL have ports imem_req in 1, imem_addr in MEM_ADDR_W; fetch requester, read-only.
REQ-005 SHALL have ports imem_gnt out 1, imem_err out 1, imem_rdata out MEM_DATA_W; fetch response, valid when imem_gnt=1.
REQ-006 SHALL have ports dmem_req in 1, dmem_addr in MEM_ADDR_W, dmem_wen in 1, dmem_strb in MEM_STRB_W, dmem_wdata in MEM_DATA_W; LSU requester.
REQ-007 SHALL have ports dmem_gnt out 1, dmem_err out 1, dmem_rdata out MEM_DATA_W; LSU response, valid when dmem_gnt=1.
REQ-008 SHALL have ports mem_req out 1, mem_addr out MEM_ADDR_W, mem_wen out 1, mem_strb out MEM_STRB_W, mem_wdata out MEM_DATA_W, mem_gnt in 1; shared address phase.
REQ-009 SHALL have ports mem_rsp in 1, mem_err in 1, mem_rdata in MEM_DATA_W; shared response phase.

Function
REQ-010 SHALL implement states IDLE, ADDR, RESP; at most one transaction outstanding.
REQ-011 IDLE: any requester asserted -> pick owner, drive mem_req=1 same cycle (zero added latency); mem_gnt=1 -> RESP; mem_gnt=0 -> ADDR.
REQ-012 ADDR: mem_req=1 with the latched owner's fields; owner SHALL NOT change until mem_gnt; mem_gnt -> RESP.
REQ-013 RESP: mem_req=0; mem_rsp=1 -> pulse owner's gnt for one cycle with mem_rdata and mem_err forwarded combinationally; then IDLE.
REQ-014 Next arbitration SHALL start no earlier than the cycle after mem_rsp; back-to-back cost = 1 idle cycle.
REQ-015 Priority: data over fetch, except when starve counter == STARVE_LIMIT and imem_req=1, then fetch wins.
REQ-016 Starve counter: +1 on data address acceptance while imem_req=1; saturates at STARVE_LIMIT; cleared on fetch acceptance or any cycle with imem_req=0.
REQ-017 Fetch-owned transaction SHALL drive mem_wen=0, mem_strb=0, mem_wdata=0.
REQ-018 Non-owner gnt SHALL stay 0; rdata/err outputs SHALL be 0 when the matching gnt is 0.
REQ-019 mem_rsp in IDLE or ADDR SHALL be ignored (no gnt produced).
REQ-020 Requesters hold req and fields stable until their gnt; req deassert before gnt is a protocol violation, not handled.
REQ-021 Simultaneous imem_req/dmem_req in IDLE SHALL resolve per REQ-015 in that same cycle.

Reset
REQ-022 g_resetn=0 SHALL force IDLE, starve counter 0, owner data; mem_req, imem_gnt, dmem_gnt = 0.
REQ-023 Reset mid-transaction SHALL abandon the outstanding transaction; a late mem_rsp after reset SHALL be ignored per REQ-019.

Structure
REQ-024 MEM_ADDR_W, MEM_DATA_W, MEM_STRB_W and the state encoding SHALL live in the shared core_common package/header.
REQ-025 Starve counter and priority pick SHALL be one sub-module, core_mem_arbiter_prio; rest stays flat.

Verification
REQ-026 Data-only read addr 0x1000, mem_gnt immediate, mem_rsp 2 cycles later, rdata 0xDEADBEEF -> dmem_gnt one cycle with rdata 0xDEADBEEF, imem_gnt=0.
REQ-027 Both requesting in IDLE, counter 0 -> data address on mem_addr first; fetch issued the cycle after data response.
REQ-028 dmem_req held continuously, imem_req held, STARVE_LIMIT=4 -> 4 data transactions, then fetch transaction 5th; counter cleared.
REQ-029 mem_gnt withheld 3 cycles while dmem_req arrives mid-ADDR of fetch -> mem_addr stays fetch address, owner unchanged until gnt.
REQ-030 Store addr 0x20, strb 0x0F, mem_err=1 on response -> dmem_gnt=1, dmem_err=1; fetch mem_wen/mem_strb observed 0 on next fetch.
REQ-031 Reset asserted in RESP, mem_rsp arrives after reset release -> no gnt pulse, state IDLE, mem_req=0 until a new request.
